// File: rtl/cpu3_core.sv
// cpu3_core: multicycle CPU executing 16-bit instructions from an async-read ROM.
// Format op[15:12] ra[11:9] rb[8:6] imm6[5:0]; 8-entry register file (r0 reads 0);
// data memory reached through a req/ack handshake.
// Optional feature macro: CPU3_HALT_EN (opcode F becomes HALT; otherwise F is a NOP).
module cpu3_core #(
   parameter int DW  = 8,
   parameter int PCW = 6,
   parameter int AW  = 6
) (
   input  logic           clk,
   input  logic           rst,
   output logic [PCW-1:0] imem_addr,
   input  logic [15:0]    imem_data,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [AW-1:0]  dmem_addr,
   output logic [DW-1:0]  dmem_wdata,
   input  logic [DW-1:0]  dmem_rdata,
   input  logic           dmem_ack,
   output logic [PCW-1:0] pc,
   output logic           retire,
   output logic           halted
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BLT  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
`ifdef CPU3_HALT_EN
   localparam logic [3:0] OP_HALT = 4'hF;
`endif

   state_t               state;
   logic [15:0]          ir;
   logic [DW-1:0]        regs [0:7];
   logic signed [DW-1:0] a_q;
   logic signed [DW-1:0] b_q;
   logic signed [DW-1:0] res_q;
   logic signed [DW-1:0] alu;
   logic [3:0]           op;
   logic [2:0]           ra;
   logic [2:0]           rb;
   logic [5:0]           imm6;
   logic [PCW-1:0]       pc_inc;
   logic [PCW-1:0]       br_tgt;
   logic [PCW-1:0]       jmp_tgt;
   logic                 taken;

   // Sign-extend a 6-bit immediate to the datapath width.
   function automatic logic signed [DW-1:0] sx_dw(input logic [5:0] v);
      logic signed [5:0] s;
      s = v;
      return DW'(s);
   endfunction

   // Sign-extend a 6-bit immediate to the program counter width.
   function automatic logic [PCW-1:0] sx_pc(input logic [5:0] v);
      logic signed [5:0] s;
      s = v;
      return PCW'(s);
   endfunction

   assign op        = ir[15:12];
   assign ra        = ir[11:9];
   assign rb        = ir[8:6];
   assign imm6      = ir[5:0];
   assign imem_addr = pc;
   assign pc_inc    = pc + PCW'(1);
   assign br_tgt    = pc_inc + sx_pc(imm6);
   // JMP takes the zero-extended low bits of the 12-bit ra/rb/imm field.
   assign jmp_tgt   = PCW'(ir[11:0]);
   assign taken     = ((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BLT) && (a_q < b_q));

   // ALU result, or effective address for loads and stores.
   always_comb begin
      alu = a_q + b_q;
      case (op)
         OP_SUB:        alu = a_q - b_q;
         OP_AND:        alu = a_q & b_q;
         OP_OR:         alu = a_q | b_q;
         OP_ADDI:       alu = a_q + sx_dw(imm6);
         OP_LD, OP_ST:  alu = b_q + sx_dw(imm6);
         default:       alu = a_q + b_q;
      endcase
   end

   // Retire marks the last cycle of an instruction, i.e. the cycle that leaves for FETCH (or HALT).
   always_comb begin
      retire = 1'b0;
      if (!rst) begin
         case (state)
            S_EXEC:  retire = !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST});
            S_MEM:   retire = dmem_ack && (op == OP_ST);
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
         endcase
      end
   end

   // Main control FSM: sequencing, pc update and the registered memory interface.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         pc         <= '0;
         ir         <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
`ifdef CPU3_HALT_EN
         halted     <= 1'b0;
`endif
      end else begin
         case (state)
            S_FETCH: begin
               ir    <= imem_data;
               state <= S_DECODE;
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state <= S_WB;
                  OP_LD, OP_ST: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_ST);
                     dmem_addr  <= AW'(alu);
                     dmem_wdata <= a_q;
                     state      <= S_MEM;
                  end
                  OP_BEQ, OP_BLT: begin
                     pc    <= taken ? br_tgt : pc_inc;
                     state <= S_FETCH;
                  end
                  OP_JMP: begin
                     pc    <= jmp_tgt;
                     state <= S_FETCH;
                  end
`ifdef CPU3_HALT_EN
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
`endif
                  default: begin
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (op == OP_ST) begin
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               pc    <= pc_inc;
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifndef CPU3_HALT_EN
   assign halted = 1'b0;
`endif

   // Operand latches and result register; pure datapath, no reset needed.
   always_ff @(posedge clk) begin
      if (state == S_DECODE) begin
         a_q <= (ra == 3'd0) ? '0 : regs[ra];
         b_q <= (rb == 3'd0) ? '0 : regs[rb];
      end
      if (state == S_EXEC) begin
         res_q <= alu;
      end else if ((state == S_MEM) && dmem_ack) begin
         res_q <= dmem_rdata;
      end
   end

   // Register file write port; r0 is never written so it always reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if ((state == S_WB) && (ra != 3'd0)) begin
         regs[ra] <= res_q;
      end
   end

endmodule
